pwm_decoder: RTL and testbench

//  Receive end of the motor PWM link. Samples an asynchronous PWM line and measures high time and

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_sync.sv | 37 +++
 rtl/pwm_decoder.sv | 79 +++++++
 tb/tb_pwm_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared decoder state type and PWM link frame constants
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, MEAS, STALL} pwm_dec_state_t;
  localparam int PWM_FRAME = 256;
  localparam int PWM_SPEED_OFS = 128;
endpackage

// File: rtl/pwm_sync.sv
// pwm_sync: 2-flop synchronizer, optional glitch filter (PWM_DEC_FILTER_EN), rise detect
module pwm_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  if (FILT_LEN < 1) begin : g_bad
    $error("FILT_LEN must be at least 1");
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {pwm_in, s1, level};
`ifdef PWM_DEC_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [CW-1:0] cnt;
  logic filt;
  // level flips only once s2 has disagreed with it for FILT_LEN cycles in a row
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) cnt <= '0;
    else if (cnt == CW'(FILT_LEN - 1)) begin
      filt <= s2;
      cnt  <= '0;
    end else cnt <= cnt + 1'b1;
  assign level = filt;
`else
  assign level = s2;
`endif
  assign rise = level & ~s3;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures PWM high time/period and recovers the 7-bit speed command
// Glitch filter on the sampled line is enabled with PWM_DEC_FILTER_EN.
module pwm_decoder import pwm_pkg::*; #(
  parameter int CNT_W     = 16,
  parameter int SPEED_OFS = PWM_SPEED_OFS,
  parameter int TIMEOUT   = 1024,
  parameter int FILT_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [6:0]       speed,
  output logic             valid,
  output logic             update,
  output logic             stalled,
  output logic             level
);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONES = '1;
  pwm_dec_state_t state, state_d;
  logic rise, publish, stall_go;
  logic [CNT_W-1:0] per_cnt, hi_cnt, stall_val, pub_hi;
  logic signed [CNT_W:0] diff;
  logic [6:0] speed_d;
  if (TIMEOUT < 1 || TIMEOUT >= 2 ** CNT_W) begin : g_bad
    $error("TIMEOUT must fit in CNT_W bits");
  end
  pwm_sync #(.FILT_LEN(FILT_LEN)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise)
  );
  // a rise always wins over a simultaneous timeout
  always_comb begin
    publish   = rise && state == MEAS;
    stall_go  = !rise && state != STALL && per_cnt >= TMO;
    state_d   = rise ? MEAS : stall_go ? STALL : state;
    stall_val = level ? TMO : '0;
    pub_hi    = publish ? hi_cnt : stall_val;
    diff      = $signed({1'b0, pub_hi}) - $signed((CNT_W + 1)'(SPEED_OFS));
    speed_d   = diff[CNT_W] ? 7'd0 : diff[CNT_W-1:0] > CNT_W'(127) ? 7'd127 : diff[6:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      high_time <= '0;
      period    <= '0;
      speed     <= '0;
      valid     <= 1'b0;
      update    <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      update <= publish;
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
        stalled <= 1'b0;
      end else if (state != STALL) begin
        per_cnt <= per_cnt == ONES ? per_cnt : per_cnt + 1'b1;
        hi_cnt  <= level && hi_cnt != ONES ? hi_cnt + 1'b1 : hi_cnt;
      end
      // while stalled the outputs track the stuck line level
      if (publish || stall_go || (state == STALL && !rise)) begin
        high_time <= pub_hi;
        period    <= publish ? per_cnt : stall_val;
        speed     <= speed_d;
        valid     <= publish;
      end
      if (stall_go) stalled <= 1'b1;
    end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: randomized frame stimulus checked against a frame-level reference model
module tb_pwm_decoder;
  import pwm_pkg::*;
  localparam int TIMEOUT = 1024;
  typedef struct packed {int h; int p;} frame_t;
  typedef struct packed {logic [15:0] ht; logic [15:0] per; logic [6:0] spd; logic vld;} obs_t;
  logic clk = 1'b0, rst = 1'b0, pwm_in = 1'b0;
  logic [15:0] high_time, period;
  logic [6:0] speed;
  logic valid, update, stalled, level;
  int n_checks = 0, n_fail = 0;
  bit saw_level;
  frame_t frames[$];
  obs_t obs_q[$];

  pwm_decoder #(.CNT_W(16), .SPEED_OFS(PWM_SPEED_OFS), .TIMEOUT(TIMEOUT), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .high_time(high_time), .period(period),
    .speed(speed), .valid(valid), .update(update), .stalled(stalled), .level(level)
  );

  always #5 clk = ~clk;

  function automatic obs_t model(frame_t f);
    int d = f.h - PWM_SPEED_OFS;
    return '{ht: 16'(f.h), per: 16'(f.p), spd: 7'(d < 0 ? 0 : d > 127 ? 127 : d), vld: 1'b1};
  endfunction

  task automatic drive(bit v, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 pwm_in = v;
      @(negedge clk);
      if (update) obs_q.push_back('{ht: high_time, per: period, spd: speed, vld: valid});
      if (level) saw_level = 1'b1;
    end
  endtask

  task automatic apply_reset();
    pwm_in = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    obs_q.delete();
    saw_level = 1'b0;
  endtask

  task automatic add(int h, int p);
    frames.push_back('{h: h, p: p});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({high_time, period, speed, valid, update, stalled, level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ht=%0d per=%0d spd=%0d v=%b u=%b s=%b l=%b, required all 0",
               high_time, period, speed, valid, update, stalled, level);
    end
    pwm_in = 1'b0;
  endtask

  // every sent frame is published once the next rise arrives; a trailing rise flushes the last one
  task automatic test_frames(string name);
    obs_t e;
    apply_reset();
    foreach (frames[i]) begin
      drive(1'b1, frames[i].h);
      drive(1'b0, frames[i].p - frames[i].h);
    end
    drive(1'b1, 12);
    drive(1'b0, 12);
    n_checks++;
    if (obs_q.size() != frames.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d updates, required %0d", name, obs_q.size(), frames.size());
    end
    for (int i = 0; i < frames.size() && i < obs_q.size(); i++) begin
      e = model(frames[i]);
      n_checks++;
      if (obs_q[i] !== e) begin
        n_fail++;
        $display("FAIL %s_frame%0d: got ht=%0d per=%0d spd=%0d v=%b, required ht=%0d per=%0d spd=%0d v=1",
                 name, i, obs_q[i].ht, obs_q[i].per, obs_q[i].spd, obs_q[i].vld, e.ht, e.per, e.spd);
      end
    end
    frames.delete();
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(400, 8);
      add($urandom_range(p - 4, 4), p);
    end
    test_frames("random");
  endtask

  task automatic test_stall();
    obs_t e0, e1;
    apply_reset();
    drive(1'b1, 128);
    drive(1'b0, 128);
    drive(1'b0, TIMEOUT - 256 - 10);
    n_checks++;
    if (stalled !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early: got stalled=%b, required 0", stalled);
    end
    drive(1'b0, 40);
    n_checks++;
    if ({stalled, valid, high_time, period, speed} !== {1'b1, 1'b0, 39'd0} || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_low: got s=%b v=%b ht=%0d per=%0d spd=%0d upd=%0d, required s=1 v=0 ht=0 per=0 spd=0 upd=0",
               stalled, valid, high_time, period, speed, obs_q.size());
    end
    drive(1'b1, 128);
    n_checks++;
    if ({stalled, valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_resume: got s=%b v=%b, required s=0 v=0", stalled, valid);
    end
    drive(1'b0, 128);
    drive(1'b1, 100);
    drive(1'b0, 156);
    drive(1'b1, 12);
    drive(1'b0, 12);
    e0 = model('{h: 128, p: 256});
    e1 = model('{h: 100, p: 256});
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== e0 || obs_q[1] !== e1) begin
      n_fail++;
      $display("FAIL stall_recover: got %0d updates, required 2 matching (128,256),(100,256)", obs_q.size());
    end
    drive(1'b1, 1100);
    n_checks++;
    if ({stalled, valid, high_time, period, speed} !== {1'b1, 1'b0, 16'(TIMEOUT), 16'(TIMEOUT), 7'd127}) begin
      n_fail++;
      $display("FAIL stall_high: got s=%b v=%b ht=%0d per=%0d spd=%0d, required s=1 v=0 ht=%0d per=%0d spd=127",
               stalled, valid, high_time, period, speed, TIMEOUT, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e0, e1;
    apply_reset();
    drive(1'b1, 150);
    drive(1'b0, 106);
    drive(1'b1, 50);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL rmid_pre: got %0d updates, required 1", obs_q.size());
    end
    #2 rst = 1'b0;
    pwm_in = 1'b0;
    #1;
    n_checks++;
    if ({high_time, period, speed, valid, update, stalled, level} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: got ht=%0d per=%0d spd=%0d v=%b, required all 0", high_time, period, speed, valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    obs_q.delete();
    drive(1'b1, 200);
    drive(1'b0, 56);
    n_checks++;
    if (obs_q.size() != 0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_first_rise: got %0d updates valid=%b, required 0 updates valid=0", obs_q.size(), valid);
    end
    drive(1'b1, 200);
    drive(1'b0, 56);
    drive(1'b1, 12);
    drive(1'b0, 12);
    e0 = model('{h: 200, p: 256});
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== e0 || obs_q[1] !== e0) begin
      n_fail++;
      e1 = obs_q.size() > 0 ? obs_q[0] : '0;
      $display("FAIL rmid_publish: got %0d updates first ht=%0d per=%0d, required 2 with ht=200 per=256",
               obs_q.size(), e1.ht, e1.per);
    end
  endtask

  task automatic test_glitch();
`ifdef PWM_DEC_FILTER_EN
    apply_reset();
    drive(1'b1, 1);
    drive(1'b0, 20);
    drive(1'b1, 2);
    drive(1'b0, 20);
    drive(1'b1, 1);
    drive(1'b0, 20);
    n_checks++;
    if (obs_q.size() != 0 || saw_level) begin
      n_fail++;
      $display("FAIL glitch_filtered: got %0d updates level_seen=%b, required 0 and 0", obs_q.size(), saw_level);
    end
`else
    add(1, 21);
    add(2, 22);
    test_frames("glitch");
`endif
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 3; i++) add(PWM_SPEED_OFS, PWM_FRAME);
    test_frames("gen_speed0");
    add(255, 256);
    add(255, 256);
    add(192, 256);
    add(192, 256);
    test_frames("speed_change");
    add(100, 256);
    add(290, 300);
    test_frames("saturation");
    test_random();
    test_stall();
    test_reset_mid();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
